// File: rtl/step_controller.sv
// Execution sequencer for the MIPS debugger: issues the one-cycle stepEnable
// advance pulse from manual steps, divided free-run, and breakpoint/halt stops.
module step_controller #(
    parameter int unsigned RUN_DIV   = 5000000,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 stepButton,
    input  logic                 runSwitch,
    input  logic                 bpEnable,
    input  logic [31:0]          bpAddr,
    input  logic [31:0]          pcAddr,
    input  logic [31:0]          instruction,
    output logic                 stepEnable,
    output logic                 running,
    output logic                 bpHit,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stepCount
);

    localparam int unsigned          DIV_W    = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BREAK,
        HALT
    } state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] divider, divider_next;
    logic             bp_armed, bp_armed_next;
    logic             pulse;
    logic             is_halt;
    logic             bp_match;

    assign is_halt  = (instruction == HALT_WORD);
    assign bp_match = bpEnable & bp_armed & (pcAddr == bpAddr);

    always_comb begin
        state_next    = state;
        divider_next  = divider;
        bp_armed_next = bp_armed;
        pulse         = 1'b0;
        case (state)
            IDLE: begin
                // A run request swallows a coincident button press.
                if (runSwitch) begin
                    state_next   = RUN;
                    divider_next = '0;
                end else if (stepButton) begin
                    if (is_halt) state_next = HALT;
                    else         pulse      = 1'b1;
                end
            end
            RUN: begin
                if (!runSwitch) begin
                    state_next   = IDLE;
                    divider_next = '0;
                end else if (divider == DIV_LAST) begin
                    divider_next = '0;
                    if (is_halt) begin
                        state_next = HALT;
                    end else if (bp_match) begin
                        state_next    = BREAK;
                        bp_armed_next = 1'b0;
                    end else begin
                        pulse = 1'b1;
                    end
                end else begin
                    divider_next = divider + DIV_W'(1);
                end
            end
            BREAK: begin
                if (stepButton && is_halt) begin
                    state_next = HALT;
                end else begin
                    pulse = stepButton;
                    if (!runSwitch) state_next = IDLE;
                end
            end
            HALT: begin
            end
            default: state_next = IDLE;
        endcase
        if (pulse) bp_armed_next = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= IDLE;
            divider    <= '0;
            bp_armed   <= 1'b0;
            stepEnable <= 1'b0;
            stepCount  <= '0;
        end else begin
            state      <= state_next;
            divider    <= divider_next;
            bp_armed   <= bp_armed_next;
            stepEnable <= pulse;
            if (pulse && (stepCount != '1)) stepCount <= stepCount + CNT_WIDTH'(1);
        end
    end

    assign running = (state == RUN);
    assign bpHit   = (state == BREAK);
    assign halted  = (state == HALT);

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: directed scenarios plus random traffic, all
// checked each cycle against a cycle-level behavioural model.
module tb_step_controller;

    localparam int          RUN_DIV   = 4;
    localparam logic [31:0] HALT_WORD = 32'hFFFFFFFF;
    localparam logic [31:0] NOP_WORD  = 32'h20080005;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        stepButton = 1'b0;
    logic        runSwitch = 1'b0;
    logic        bpEnable = 1'b0;
    logic [31:0] bpAddr = '0;
    logic [31:0] pcAddr = '0;
    logic [31:0] instruction = NOP_WORD;

    logic        stepEnable, running, bpHit, halted;
    logic [15:0] stepCount;
    logic        s_stepEnable, s_running, s_bpHit, s_halted;
    logic [2:0]  s_stepCount;

    always #5 Clk = ~Clk;

    step_controller #(.RUN_DIV(RUN_DIV), .HALT_WORD(HALT_WORD), .CNT_WIDTH(16)) dut (
        .Clk(Clk), .Rst(Rst), .stepButton(stepButton), .runSwitch(runSwitch),
        .bpEnable(bpEnable), .bpAddr(bpAddr), .pcAddr(pcAddr), .instruction(instruction),
        .stepEnable(stepEnable), .running(running), .bpHit(bpHit), .halted(halted),
        .stepCount(stepCount)
    );

    // Narrow counter copy so saturation is reached within a short run.
    step_controller #(.RUN_DIV(RUN_DIV), .HALT_WORD(HALT_WORD), .CNT_WIDTH(3)) dut_small (
        .Clk(Clk), .Rst(Rst), .stepButton(stepButton), .runSwitch(runSwitch),
        .bpEnable(bpEnable), .bpAddr(bpAddr), .pcAddr(pcAddr), .instruction(instruction),
        .stepEnable(s_stepEnable), .running(s_running), .bpHit(s_bpHit), .halted(s_halted),
        .stepCount(s_stepCount)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode, cycles spent in the current run, arming flag, counts.
    localparam int M_IDLE = 0, M_RUN = 1, M_BRK = 2, M_HALT = 3;
    int m_mode   = M_IDLE;
    int m_runcyc = 0;
    int m_total  = 0;
    int m_cnt16  = 0;
    int m_cnt3   = 0;
    bit m_armed  = 1'b0;
    bit m_step   = 1'b0;
    bit m_fire, m_hw, m_bpm;

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_mode = M_IDLE; m_runcyc = 0; m_armed = 1'b0; m_step = 1'b0;
            m_cnt16 = 0; m_cnt3 = 0;
        end else begin
            m_fire = 1'b0;
            m_hw   = (instruction == HALT_WORD);
            m_bpm  = bpEnable && m_armed && (pcAddr == bpAddr);
            if (m_mode == M_IDLE) begin
                if (runSwitch) begin m_mode = M_RUN; m_runcyc = 0; end
                else if (stepButton) begin
                    if (m_hw) m_mode = M_HALT; else m_fire = 1'b1;
                end
            end else if (m_mode == M_RUN) begin
                if (!runSwitch) m_mode = M_IDLE;
                else begin
                    m_runcyc++;
                    if (m_runcyc % RUN_DIV == 0) begin
                        if (m_hw) m_mode = M_HALT;
                        else if (m_bpm) begin m_mode = M_BRK; m_armed = 1'b0; end
                        else m_fire = 1'b1;
                    end
                end
            end else if (m_mode == M_BRK) begin
                if (stepButton && m_hw) m_mode = M_HALT;
                else begin
                    m_fire = stepButton;
                    if (!runSwitch) m_mode = M_IDLE;
                end
            end
            m_step = m_fire;
            if (m_fire) begin
                m_armed = 1'b1;
                m_total++;
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt3 < 7) m_cnt3++;
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge Clk) begin
        if (chk_en) begin
            check("stepEnable", 32'(stepEnable), 32'(m_step));
            check("running", 32'(running), 32'(m_mode == M_RUN));
            check("bpHit", 32'(bpHit), 32'(m_mode == M_BRK));
            check("halted", 32'(halted), 32'(m_mode == M_HALT));
            check("stepCount", 32'(stepCount), 32'(m_cnt16));
            check("small_stepEnable", 32'(s_stepEnable), 32'(m_step));
            check("small_stepCount", 32'(s_stepCount), 32'(m_cnt3));
            check("small_halted", 32'(s_halted), 32'(m_mode == M_HALT));
        end
    end

    bit pc_track = 1'b0;
    int pc_base  = 0;

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #2;
            if (pc_track) pcAddr = 32'(4 * (m_total - pc_base));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 Rst = 1'b0;
        chk_en = 1'b1;
        cyc(2);
        check("rst_stepEnable", 32'(stepEnable), 32'd0);
        check("rst_stepCount", 32'(stepCount), 32'd0);
        check("rst_status", {29'd0, running, bpHit, halted}, 32'd0);
        Rst = 1'b1;
        cyc();

        // Manual step from IDLE
        stepButton = 1'b1;
        cyc();
        check("man_pulse", 32'(stepEnable), 32'd1);
        check("man_count", 32'(stepCount), 32'd1);
        stepButton = 1'b0;
        cyc();
        check("man_pulse_end", 32'(stepEnable), 32'd0);
        check("man_idle", 32'(running), 32'd0);

        // Free run over 21 edges yields 5 pulses
        runSwitch = 1'b1;
        n = 0;
        repeat (21) begin cyc(); if (stepEnable) n++; end
        check("run_pulses", 32'(n), 32'd5);
        check("run_running", 32'(running), 32'd1);
        check("run_count", 32'(stepCount), 32'd6);
        runSwitch = 1'b0;
        cyc();

        // Breakpoint at 0x0C with PC advancing 4 per pulse
        pc_base = m_total; pc_track = 1'b1; pcAddr = '0;
        bpAddr = 32'h0000000C; bpEnable = 1'b1; runSwitch = 1'b1;
        n = 0;
        while (!bpHit && n < 40) begin cyc(); n++; end
        check("bp_reached", 32'(bpHit), 32'd1);
        check("bp_not_running", 32'(running), 32'd0);
        check("bp_pc", pcAddr, 32'h0000000C);
        check("bp_count", 32'(stepCount), 32'd9);
        check("sat_small_count", 32'(s_stepCount), 32'd7);
        stepButton = 1'b1;
        cyc();
        check("bp_manual_pulse", 32'(stepEnable), 32'd1);
        check("bp_stay", 32'(bpHit), 32'd1);
        stepButton = 1'b0; runSwitch = 1'b0; pc_track = 1'b0; pcAddr = 32'h0000000C;
        cyc();
        check("bp_exit_idle", 32'(bpHit), 32'd0);
        runSwitch = 1'b1;
        cyc(5);
        check("bp_rehit_armed", 32'(bpHit), 32'd1);
        check("bp_rehit_nopulse", 32'(stepEnable), 32'd0);
        runSwitch = 1'b0;
        cyc();
        runSwitch = 1'b1;
        cyc(5);
        check("bp_resume_pulse", 32'(stepEnable), 32'd1);
        check("bp_resume_nohit", 32'(bpHit), 32'd0);
        check("bp_resume_count", 32'(stepCount), 32'd11);
        bpEnable = 1'b0; runSwitch = 1'b0;
        cyc();

        // Button and run together, then run falling on terminal count
        stepButton = 1'b1; runSwitch = 1'b1;
        cyc();
        check("sim_nopulse", 32'(stepEnable), 32'd0);
        check("sim_running", 32'(running), 32'd1);
        stepButton = 1'b0;
        cyc(3);
        check("sim_wait", 32'(stepEnable), 32'd0);
        cyc();
        check("sim_first_pulse", 32'(stepEnable), 32'd1);
        check("sim_count", 32'(stepCount), 32'd12);
        cyc(3);
        runSwitch = 1'b0;
        cyc();
        check("fall_nopulse", 32'(stepEnable), 32'd0);
        check("fall_idle", 32'(running), 32'd0);
        check("fall_count", 32'(stepCount), 32'd12);

        // Reset while a pulse is due
        runSwitch = 1'b1;
        cyc(4);
        Rst = 1'b0;
        #1;
        check("arst_count", 32'(stepCount), 32'd0);
        check("arst_status", {29'd0, running, bpHit, halted}, 32'd0);
        cyc();
        check("arst_nopulse", 32'(stepEnable), 32'd0);
        runSwitch = 1'b0;
        cyc();
        Rst = 1'b1;
        cyc();

        // Halt at RUN terminal count, then everything ignored
        runSwitch = 1'b1; instruction = HALT_WORD;
        cyc(5);
        check("halt_set", 32'(halted), 32'd1);
        check("halt_nopulse", 32'(stepEnable), 32'd0);
        check("halt_not_running", 32'(running), 32'd0);
        n = 0;
        for (int i = 0; i < 24; i++) begin
            stepButton = (i % 3 == 0);
            runSwitch  = (i % 5 < 2);
            cyc();
            if (stepEnable) n++;
        end
        check("halt_no_pulses", 32'(n), 32'd0);
        check("halt_sticky", 32'(halted), 32'd1);
        stepButton = 1'b0; runSwitch = 1'b0;
        Rst = 1'b0;
        cyc();
        Rst = 1'b1;
        cyc();

        // Manual step onto a halt word in IDLE
        stepButton = 1'b1;
        cyc();
        check("idle_halt", 32'(halted), 32'd1);
        check("idle_halt_nopulse", 32'(stepEnable), 32'd0);
        stepButton = 1'b0; Rst = 1'b0;
        cyc();
        Rst = 1'b1; instruction = NOP_WORD;
        cyc();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            Rst = ($urandom % 150 != 0);
            if ($urandom % 24 == 0) runSwitch = ~runSwitch;
            if ($urandom % 20 == 0) bpEnable = ~bpEnable;
            if ($urandom % 40 == 0) bpAddr = 32'(4 * $urandom_range(0, 3));
            stepButton  = ($urandom % 6 == 0);
            pcAddr      = 32'(4 * $urandom_range(0, 3));
            instruction = ($urandom % 90 == 0) ? HALT_WORD : NOP_WORD;
            cyc();
        end
        Rst = 1'b1;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
